// File: rtl/cim_inst_sequencer_pkg.sv
// Shared CIM instruction word layout, op classes and error codes used by the
// instruction sequencer and its field decoder.
package cim_inst_sequencer_pkg;

    localparam int OP_FIELD_WIDTH  = 5;
    localparam int INST_ADDR_WIDTH = 9;

    localparam int OP_H = 31;
    localparam int OP_L = 27;
    localparam int S1_H = 26;
    localparam int S1_L = 18;
    localparam int S2_H = 17;
    localparam int S2_L = 9;
    localparam int D1_H = 8;
    localparam int D1_L = 0;

    typedef struct packed {
        logic [OP_FIELD_WIDTH-1:0]  op;
        logic [INST_ADDR_WIDTH-1:0] s1;
        logic [INST_ADDR_WIDTH-1:0] s2;
        logic [INST_ADDR_WIDTH-1:0] d1;
    } inst_fields_t;

    // Class is the top two opcode bits.
    typedef enum logic [1:0] {
        CLS_NOP     = 2'd0,
        CLS_UNARY   = 2'd1,
        CLS_BINARY  = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_S1 = 2'd1,
        RD_S2 = 2'd2,
        WR_D1 = 2'd3
    } seq_state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL_OP = 2'd1;
    localparam logic [1:0] ERR_ADDR_RANGE = 2'd2;

endpackage

// File: rtl/cim_inst_field_decode.sv
// Combinational unpack of a CIM instruction word: field split, op class and
// range check of the address fields the class actually uses.
module cim_inst_field_decode
    import cim_inst_sequencer_pkg::*;
#(
    parameter int ADDR_DEPTH = 512
) (
    input  logic [31:0] inst_data,
    output inst_fields_t fields,
    output op_class_t    op_class,
    output logic [1:0]   err_code
);

    localparam logic [31:0] DEPTH_U = 32'(ADDR_DEPTH);

    logic s1_oor;
    logic s2_oor;
    logic d1_oor;

    assign fields.op = inst_data[OP_H:OP_L];
    assign fields.s1 = inst_data[S1_H:S1_L];
    assign fields.s2 = inst_data[S2_H:S2_L];
    assign fields.d1 = inst_data[D1_H:D1_L];

    assign op_class = op_class_t'(fields.op[OP_FIELD_WIDTH-1 -: 2]);

    assign s1_oor = 32'(fields.s1) >= DEPTH_U;
    assign s2_oor = 32'(fields.s2) >= DEPTH_U;
    assign d1_oor = 32'(fields.d1) >= DEPTH_U;

    // Illegal opcode wins over a range failure; NOP fields are never checked.
    always_comb begin
        err_code = ERR_NONE;
        unique case (op_class)
            CLS_ILLEGAL: err_code = ERR_ILLEGAL_OP;
            CLS_UNARY:   if (s1_oor || d1_oor) err_code = ERR_ADDR_RANGE;
            CLS_BINARY:  if (s1_oor || s2_oor || d1_oor) err_code = ERR_ADDR_RANGE;
            default:     err_code = ERR_NONE;
        endcase
    end

endmodule

// File: rtl/cim_inst_sequencer.sv
// Accepts packed CIM instructions and expands each into RD s1, [RD s2], WR d1
// array commands; reports bad words and counts retired instructions.
module cim_inst_sequencer
    import cim_inst_sequencer_pkg::*;
#(
    parameter int ADDR_DEPTH = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic [31:0]               inst_data,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic                      cmd_we,
    output logic [ADDR_WIDTH-1:0]     cmd_addr,
    output logic [OP_FIELD_WIDTH-1:0] cmd_op,
    output logic                      cmd_last,
    output logic                      err_valid,
    output logic [1:0]                err_code,
    output logic [CNT_WIDTH-1:0]      retired_cnt
);

    seq_state_t   state_q, state_nxt;
    inst_fields_t dec_fields;
    op_class_t    dec_class;
    logic [1:0]   dec_err;
    inst_fields_t fields_q;
    inst_fields_t src;
    logic         binary_q;

    logic                      accept;
    logic                      cmd_hs;
    logic                      load;
    logic                      retire;
    logic                      err_valid_nxt;
    logic [1:0]                err_code_nxt;
    logic                      cmd_valid_nxt;
    logic                      cmd_we_nxt;
    logic                      cmd_last_nxt;
    logic [ADDR_WIDTH-1:0]     cmd_addr_nxt;
    logic [OP_FIELD_WIDTH-1:0] cmd_op_nxt;

    cim_inst_field_decode #(
        .ADDR_DEPTH (ADDR_DEPTH)
    ) u_decode (
        .inst_data (inst_data),
        .fields    (dec_fields),
        .op_class  (dec_class),
        .err_code  (dec_err)
    );

    assign inst_ready = (state_q == IDLE);
    assign accept     = inst_valid && inst_ready;
    assign cmd_hs     = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt     = state_q;
        load          = 1'b0;
        retire        = 1'b0;
        err_valid_nxt = 1'b0;
        err_code_nxt  = ERR_NONE;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_err != ERR_NONE) begin
                        err_valid_nxt = 1'b1;
                        err_code_nxt  = dec_err;
                    end else if (dec_class == CLS_NOP) begin
                        retire = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RD_S1;
                    end
                end
            end
            RD_S1: if (cmd_hs) state_nxt = binary_q ? RD_S2 : WR_D1;
            RD_S2: if (cmd_hs) state_nxt = WR_D1;
            WR_D1: begin
                if (cmd_hs) begin
                    state_nxt = IDLE;
                    retire    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Command registers are loaded from the next state so the first
        // command appears right after acceptance and no gap follows a handshake.
        src           = load ? dec_fields : fields_q;
        cmd_valid_nxt = 1'b0;
        cmd_we_nxt    = 1'b0;
        cmd_last_nxt  = 1'b0;
        cmd_addr_nxt  = '0;
        cmd_op_nxt    = '0;
        unique case (state_nxt)
            RD_S1: begin
                cmd_valid_nxt = 1'b1;
                cmd_addr_nxt  = ADDR_WIDTH'(src.s1);
                cmd_op_nxt    = src.op;
            end
            RD_S2: begin
                cmd_valid_nxt = 1'b1;
                cmd_addr_nxt  = ADDR_WIDTH'(src.s2);
                cmd_op_nxt    = src.op;
            end
            WR_D1: begin
                cmd_valid_nxt = 1'b1;
                cmd_we_nxt    = 1'b1;
                cmd_last_nxt  = 1'b1;
                cmd_addr_nxt  = ADDR_WIDTH'(src.d1);
                cmd_op_nxt    = src.op;
            end
            default: cmd_valid_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_valid   <= 1'b0;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_op      <= '0;
            cmd_last    <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= ERR_NONE;
            retired_cnt <= '0;
        end else begin
            state_q   <= state_nxt;
            cmd_valid <= cmd_valid_nxt;
            cmd_we    <= cmd_we_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_op    <= cmd_op_nxt;
            cmd_last  <= cmd_last_nxt;
            err_valid <= err_valid_nxt;
            err_code  <= err_code_nxt;
            if (retire) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
        end
    end

    // Field holding registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            fields_q <= dec_fields;
            binary_q <= (dec_class == CLS_BINARY);
        end
    end

endmodule

// File: tb/tb_cim_inst_sequencer.sv
// Bench for cim_inst_sequencer: directed scenarios plus randomized instructions
// checked against a per-instruction command-list model.
module tb_cim_inst_sequencer;

    localparam int DEPTH = 256;
    localparam int AW    = 9;
    localparam int CW    = 4;

    logic          clk;
    logic          rst_n;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [4:0]    cmd_op;
    logic          cmd_last;
    logic          err_valid;
    logic [1:0]    err_code;
    logic [CW-1:0] retired_cnt;

    cim_inst_sequencer #(
        .ADDR_DEPTH (DEPTH),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_op      (cmd_op),
        .cmd_last    (cmd_last),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic          last;
    } cmd_t;

    int   errors  = 0;
    int   checks  = 0;
    int   exp_cnt = 0;
    cmd_t exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic cmd_t mk(logic we, logic [AW-1:0] addr, logic last);
        cmd_t c;
        c.we   = we;
        c.addr = addr;
        c.last = last;
        return c;
    endfunction

    function automatic logic [1:0] model_err(logic [31:0] w);
        int cls = int'(w[31:30]);
        int s1  = int'(w[26:18]);
        int s2  = int'(w[17:9]);
        int d1  = int'(w[8:0]);
        if (cls == 3) return 2'd1;
        if (cls == 1 && (s1 >= DEPTH || d1 >= DEPTH)) return 2'd2;
        if (cls == 2 && (s1 >= DEPTH || s2 >= DEPTH || d1 >= DEPTH)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic void model_cmds(logic [31:0] w);
        exp_q.delete();
        if (w[31:30] == 2'b01) begin
            exp_q.push_back(mk(1'b0, w[26:18], 1'b0));
            exp_q.push_back(mk(1'b1, w[8:0], 1'b1));
        end else if (w[31:30] == 2'b10) begin
            exp_q.push_back(mk(1'b0, w[26:18], 1'b0));
            exp_q.push_back(mk(1'b0, w[17:9], 1'b0));
            exp_q.push_back(mk(1'b1, w[8:0], 1'b1));
        end
    endfunction

    function automatic logic [31:0] mkword(int op, int s1, int s2, int d1);
        return {5'(op), 9'(s1), 9'(s2), 9'(d1)};
    endfunction

    // Accept one word, then follow its commands under the chosen cmd_ready pattern.
    task automatic run_inst(input logic [31:0] w, input int stall_first, input bit rand_stall);
        logic [1:0] e;
        int k;
        int waited;
        int cyc;
        e = model_err(w);
        model_cmds(w);
        checks++;
        if (inst_ready !== 1'b1)
            $display("FAIL ready_before_accept word=%h got=%b want=1", w, inst_ready);
        if (inst_ready !== 1'b1) errors++;
        inst_valid = 1'b1;
        inst_data  = w;
        tick();
        inst_valid = 1'b0;
        inst_data  = $urandom;
        checks++;
        if (err_valid !== (e != 2'd0) || err_code !== e) begin
            errors++;
            $display("FAIL err_pulse word=%h got=%b/%0d want=%b/%0d", w, err_valid, err_code, e != 2'd0, e);
        end
        if (e != 2'd0 || w[31:30] == 2'b00) begin
            if (e == 2'd0) exp_cnt++;
            checks++;
            if (cmd_valid !== 1'b0 || inst_ready !== 1'b1 || retired_cnt !== CW'(exp_cnt)) begin
                errors++;
                $display("FAIL no_cmd_inst word=%h got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=%0d",
                         w, cmd_valid, inst_ready, retired_cnt, CW'(exp_cnt));
            end
            return;
        end
        k = 0;
        waited = 0;
        cyc = 0;
        while (k < exp_q.size()) begin
            if (cyc > 200) begin
                errors++;
                $display("FAIL cmd_timeout word=%h got %0d cmds want %0d", w, k, exp_q.size());
                break;
            end
            checks++;
            if (cmd_valid !== 1'b1 || cmd_we !== exp_q[k].we || cmd_addr !== exp_q[k].addr ||
                cmd_last !== exp_q[k].last || cmd_op !== w[31:27]) begin
                errors++;
                $display("FAIL cmd word=%h idx=%0d got v=%b we=%b a=%0d l=%b op=%h want v=1 we=%b a=%0d l=%b op=%h",
                         w, k, cmd_valid, cmd_we, cmd_addr, cmd_last, cmd_op,
                         exp_q[k].we, exp_q[k].addr, exp_q[k].last, w[31:27]);
            end
            checks++;
            if (inst_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_while_busy word=%h idx=%0d got=%b want=0", w, k, inst_ready);
            end
            if (k == 0 && waited < stall_first) cmd_ready = 1'b0;
            else if (rand_stall)               cmd_ready = 1'($urandom_range(0, 1));
            else                               cmd_ready = 1'b1;
            tick();
            cyc++;
            if (cmd_ready) begin
                k++;
                waited = 0;
            end else begin
                waited++;
            end
        end
        cmd_ready = 1'b1;
        exp_cnt++;
        checks++;
        if (cmd_valid !== 1'b0 || inst_ready !== 1'b1 || err_valid !== 1'b0 || retired_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL retire word=%h got v=%b rdy=%b err=%b cnt=%0d want v=0 rdy=1 err=0 cnt=%0d",
                     w, cmd_valid, inst_ready, err_valid, retired_cnt, CW'(exp_cnt));
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_data  = '0;
        cmd_ready  = 1'b1;
        tick();
        tick();
        checks++;
        if (inst_ready !== 1'b1 || cmd_valid !== 1'b0 || cmd_we !== 1'b0 || cmd_addr !== '0 ||
            cmd_op !== '0 || cmd_last !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'd0 ||
            retired_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b v=%b we=%b a=%0d op=%h l=%b ev=%b ec=%0d cnt=%0d want 1,0,0,0,0,0,0,0,0",
                     inst_ready, cmd_valid, cmd_we, cmd_addr, cmd_op, cmd_last, err_valid, err_code, retired_cnt);
        end
        rst_n = 1'b1;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_binary;
        run_inst(32'h880C0805, 0, 1'b0);
    endtask

    task automatic test_unary_backpressure;
        run_inst(32'h401C0009, 3, 1'b0);
    endtask

    task automatic test_illegal;
        run_inst(32'hC0000000, 0, 1'b0);
        run_inst(mkword(5'b00011, 1, 2, 3), 0, 1'b0);
    endtask

    task automatic test_range;
        run_inst(32'h44B00009, 0, 1'b0);
        run_inst(32'h04B00009, 0, 1'b0);
        run_inst(mkword(5'b10000, 10, 256, 20), 0, 1'b0);
        run_inst(mkword(5'b10111, 255, 255, 255), 0, 1'b0);
        run_inst(mkword(5'b01010, 0, 400, 256), 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        inst_valid = 1'b1;
        inst_data  = 32'h880C0805;
        cmd_ready  = 1'b1;
        tick();
        inst_valid = 1'b0;
        tick();
        cmd_ready = 1'b0;
        tick();
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 9'd4) begin
            errors++;
            $display("FAIL pre_reset_rd_s2 got v=%b a=%0d want v=1 a=4", cmd_valid, cmd_addr);
        end
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checks++;
        if (cmd_valid !== 1'b0 || retired_cnt !== '0 || inst_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got v=%b cnt=%0d rdy=%b want v=0 cnt=0 rdy=1", cmd_valid, retired_cnt, inst_ready);
        end
        tick();
        rst_n = 1'b1;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cmd_valid !== 1'b0 || inst_ready !== 1'b1 || retired_cnt !== '0) begin
                errors++;
                $display("FAIL stale_cmd cyc=%0d got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=0",
                         i, cmd_valid, inst_ready, retired_cnt);
            end
        end
    endtask

    task automatic test_back_to_back_wrap;
        bit saw_wrap;
        logic [CW-1:0] prev;
        saw_wrap = 1'b0;
        inst_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prev = retired_cnt;
            inst_data = {2'b00, 30'($urandom)};
            tick();
            exp_cnt++;
            if (prev == 4'hF && retired_cnt == 4'h0) saw_wrap = 1'b1;
            checks++;
            if (retired_cnt !== CW'(exp_cnt) || err_valid !== 1'b0 || inst_ready !== 1'b1 || cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL nop_stream i=%0d got cnt=%0d ev=%b rdy=%b v=%b want cnt=%0d ev=0 rdy=1 v=0",
                         i, retired_cnt, err_valid, inst_ready, cmd_valid, CW'(exp_cnt));
            end
        end
        inst_valid = 1'b0;
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_15_to_0 got no wrap final=%0d want wrap", retired_cnt);
        end
    endtask

    task automatic test_random;
        int f[3];
        int op;
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 3; j++)
                f[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(256, 511)) : int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 31));
            run_inst(mkword(op, f[0], f[1], f[2]), int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_unary_backpressure();
        test_illegal();
        test_range();
        test_reset_mid();
        test_back_to_back_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/cim_inst_sequencer.md
Name: cim_inst_sequencer

Overview:
- Consumer end of the CIM instruction word: accepts 32-bit packed instructions over a valid/ready stream.
- Decodes the op, s1, s2 and d1 fields and expands each instruction into an ordered sequence of array access commands: read s1, read s2, then write d1.
- Sits between the instruction fetch/queue and the CIM array port controller.
- Flags illegal opcodes and out-of-range addresses, and counts retired instructions.

Parameters:
- ADDR_DEPTH, 512, number of valid CIM addresses. Any field with value >= ADDR_DEPTH is out of range.
- ADDR_WIDTH, 9, address field width. Must equal the shared instruction address width.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst_valid  in  1  instruction word present.
- inst_ready  out  1  sequencer can accept a word.
- inst_data  in  32  packed word: op[31:27], s1[26:18], s2[17:9], d1[8:0].
- cmd_valid  out  1  array command present.
- cmd_ready  in  1  array port accepts the command.
- cmd_we  out  1  0 = read, 1 = write.
- cmd_addr  out  ADDR_WIDTH  array address.
- cmd_op  out  5  opcode of the instruction that owns this command.
- cmd_last  out  1  final command of the instruction.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  1 = illegal opcode, 2 = address out of range; 0 when no error.
- retired_cnt  out  CNT_WIDTH  instructions completed; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, sync release): state IDLE, inst_ready=1, cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_op=0, cmd_last=0, err_valid=0, err_code=0, retired_cnt=0.
- Reset mid-sequence aborts the instruction. Commands not yet handshaked are never issued, and the instruction is not retired.
- Opcode class is op[4:3]:
  - 00 = NOP, no commands.
  - 01 = unary: RD s1, then WR d1.
  - 10 = binary: RD s1, RD s2, then WR d1.
  - 11 = illegal.
- Acceptance:
  - inst_ready = (state==IDLE), driven from registered state.
  - Handshake when inst_valid && inst_ready. The fields are latched into internal registers.
- Range check, applied at acceptance to the fields the class uses:
  - unary checks s1 and d1.
  - binary checks s1, s2 and d1.
  - A check fails when field >= ADDR_DEPTH.
  - Illegal-opcode has priority over the range error.
- Errored instruction: err_valid=1 with its err_code on the cycle after acceptance. No commands are issued, retired_cnt is unchanged, and the state stays IDLE.
- NOP: retired_cnt increments on the cycle after acceptance; the state stays IDLE.
- FSM states: IDLE, RD_S1, RD_S2, WR_D1.
  - IDLE -> RD_S1 on an accepted, legal unary or binary instruction.
  - RD_S1 -> RD_S2 (binary) or WR_D1 (unary) on cmd handshake.
  - RD_S2 -> WR_D1 on cmd handshake.
  - WR_D1 -> IDLE on cmd handshake. retired_cnt increments on that same handshake cycle.
- Command outputs are registered:
  - The first cmd_valid appears the cycle after acceptance.
  - The next command is presented the cycle after each handshake. No idle gap is allowed with cmd_ready held at 1.
  - cmd_last=1 only in WR_D1.
  - cmd_we=1 only in WR_D1.
- Backpressure: while cmd_valid && !cmd_ready, cmd_we, cmd_addr, cmd_op and cmd_last hold stable. The sequencer never drops cmd_valid without a handshake, except on reset.
- Throughput:
  - unary: 2 commands, 3 cycles accept-to-next-accept at full rate.
  - binary: 3 commands, 4 cycles at full rate.
  - inst_ready returns to 1 the cycle after the WR_D1 handshake.
- When no error is reported, err_valid and err_code are 0.
- retired_cnt wraps from all-ones to 0 without flagging.

Decomposition:
- Shared instruction package holds:
  - field bit positions (OP_H/L, S1_H/L, S2_H/L, D1_H/L), OP_FIELD_WIDTH and the address width;
  - the packed field struct;
  - new constants: the op-class enum (NOP, UNARY, BINARY, ILLEGAL) and the err_code values.
- Natural sub-module: cim_inst_field_decode, combinational. It unpacks the word, classifies the op and performs the range check. The FSM, field registers and counter stay in the top.

Test Plan:
- Binary, cmd_ready=1, inst_data=0x880C0805 (op=10001, s1=3, s2=4, d1=5) -> commands (we=0,addr=3), (we=0,addr=4), (we=1,addr=5,last=1) on consecutive cycles starting at accept+1; retired_cnt 0->1; inst_ready low 3 cycles.
- Unary 0x401C0009 (op=01000, s1=7, d1=9) with cmd_ready low for 3 cycles on the first command -> (RD 7) held stable 4 cycles, then (WR 9,last=1); retired_cnt=1.
- Illegal 0xC0000000 -> err_valid pulse with err_code=1 at accept+1; no cmd_valid; retired_cnt unchanged; next instruction accepted immediately.
- ADDR_DEPTH=256, unary with s1=300 -> err_code=2, no commands. With ADDR_DEPTH=256, the same word with op=00000 (NOP) -> no error and retired_cnt+1.
- Reset asserted while in RD_S2 with cmd_ready=0 -> cmd_valid=0 and retired_cnt=0 immediately; after release inst_ready=1 and no stale commands appear.
- CNT_WIDTH=4, 16 back-to-back NOPs -> retired_cnt wraps 15->0 with no error.
